// File: rtl/qsys_td_pio_in_irq_if.sv
// Avalon-MM slave register bus of the QsysTD input PIO.
// The master drives the address and write strobe; the slave returns zero-wait read data.
interface qsys_td_pio_in_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/qsys_td_pio_in_irq.sv
// Avalon-MM input PIO: synchronised inputs, W1C edge capture and a maskable level IRQ.
// Defining PIO_IN_DEBOUNCE_EN adds a per-bit stable-count debounce ahead of edge detection.
module qsys_td_pio_in_irq #(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned EDGE_TYPE       = 0,    // 0 rising, 1 falling, 2 any
  parameter logic [31:0] IRQ_MASK_RESET  = '0,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  qsys_td_pio_in_irq_if.slave  bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } addr_e;

  if (WIDTH < 1 || WIDTH > 32 || EDGE_TYPE > 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("qsys_td_pio_in_irq: parameter out of range");
  end

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] in_val;
  logic [WIDTH-1:0] prev_val;
  logic [1:0]       settle_cnt;
  logic             settle_done;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic             wr_en;
  logic             mask_we;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rdata;
  logic             unused_wdata;

  // Two-flop synchroniser for the asynchronous switch/key inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      // NOTE: non-blocking so each flop takes the pre-edge value of its neighbour;
      // blocking here would collapse the chain into a single stage.
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int unsigned   DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // A bit is accepted once sync2 has disagreed with the stable value for
  // DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    logic [DB_W-1:0] cnt;
    logic            stable;

    // NOTE: these per-bit counters are ordinary flops, not a RAM, so they take
    // the async reset like everything else and come up in a known state.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt    <= '0;
        stable <= 1'b0;
      end else if (sync2[i] == stable) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        stable <= sync2[i];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign in_val[i] = stable;
  end
`else
  assign in_val = sync2;
`endif

  assign settle_done = &settle_cnt;

  // Edge detection stays off for three clocks after reset release so an input
  // already high at release does not look like a fresh edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= '0;
      prev_val   <= '0;
    end else begin
      prev_val <= in_val;
      if (!settle_done) settle_cnt <= settle_cnt + 2'd1;
    end
  end

  assign rise = in_val & ~prev_val;
  assign fall = ~in_val & prev_val;

  always_comb begin
    // NOTE: default first so every path assigns edge_hit and no latch is inferred.
    edge_hit = '0;
    if (settle_done) begin
      case (EDGE_TYPE)
        0:       edge_hit = rise;
        1:       edge_hit = fall;
        default: edge_hit = rise | fall;
      endcase
    end
  end

  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign mask_we = wr_en && (bus.address == ADDR_MASK);
  assign cap_clr = (wr_en && (bus.address == ADDR_EDGE)) ? bus.writedata[WIDTH-1:0] : '0;

  // Upper write-data bits have no destination at narrow widths.
  assign unused_wdata = ^bus.writedata;

  // A new edge in the same cycle as its W1C clear wins, so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= IRQ_MASK_RESET[WIDTH-1:0];
      edgecap <= '0;
      irq     <= 1'b0;
    end else begin
      if (mask_we) irqmask <= bus.writedata[WIDTH-1:0];
      edgecap <= (edgecap & ~cap_clr) | edge_hit;
      irq     <= |(edgecap & irqmask);
    end
  end

  // Read mux ignores chipselect so the idle value is still well defined.
  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_DATA: rdata[WIDTH-1:0] = in_val;
      ADDR_MASK: rdata[WIDTH-1:0] = irqmask;
      ADDR_EDGE: rdata[WIDTH-1:0] = edgecap;
      default:   rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;

endmodule

// File: doc/qsys_td_pio_in_irq.md
Name: qsys_td_pio_in_irq

Overview:
- Avalon-MM slave input PIO. It is the read-side counterpart of the team's LED output PIO.
- Samples an external input bus (switches/keys) and synchronises it to clk, with optional debounce.
- Detects edges, latches them in a write-1-to-clear edge-capture register, and raises a maskable level interrupt to the Nios II.
- Sits in the QsysTD system beside the output PIOs on the same Avalon-MM bus.

Parameters:
- WIDTH, 10, number of input bits (1..32).
- EDGE_TYPE, 0, edge kind to capture: 0 = rising, 1 = falling, 2 = any.
- IRQ_MASK_RESET, 0, reset value of the irqmask register (WIDTH bits).
- DEBOUNCE_CYCLES, 16, stable-cycle count required before an input change is accepted. Used only with PIO_IN_DEBOUNCE_EN.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  2  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  read data, zero-wait, combinational from address.
- irq  output  1  level interrupt, registered.

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. All registers clear to 0, except irqmask, which loads IRQ_MASK_RESET.
  - Reset outputs: irq = 0; readdata is 0 for every address except 2.
  - Asserting reset mid-operation discards all captured edges immediately.
- Synchroniser: 2-flop chain per bit, sync1 then sync2. A value "in" = sync2, or the debounced value when that feature is enabled. "prev" = in delayed one clk.
- Settle counter: a 2-bit counter runs after reset deassertion. Edge detection is disabled until the counter saturates (3 clk). This prevents a spurious edge from an input that is already high at reset release.
- Edge detect, per bit:
  - rise = in & ~prev.
  - fall = ~in & prev.
  - EDGE_TYPE selects rise, fall, or rise | fall.
- Register map (word addresses):
  - 0, data, RO: readdata[WIDTH-1:0] = in. Writes are ignored.
  - 1, reserved: reads 0, writes ignored.
  - 2, irqmask, RW: written when chipselect & ~write_n & address==2, loads writedata[WIDTH-1:0].
  - 3, edgecapture, R/W1C:
    - Bit i sets on a detected edge.
    - Bit i clears on a write to address 3 with writedata[i] = 1. writedata[i] = 0 leaves it unchanged.
    - If set and clear occur in the same cycle, set wins (the edge is not lost).
- readdata:
  - Bits [31:WIDTH] are always 0.
  - The read is side-effect free and has no read latency.
  - The chipselect=0 value is don't-care but must be deterministic; drive it from the address mux regardless of chipselect.
- irq: registered each clk as |(edgecapture & irqmask).
  - Stays asserted until all masked capture bits are cleared or masked off.
  - Deasserts 1 clk after the clearing write or mask write.
- Latency, for an in_port change sampled at rising edge N (no debounce):
  - data read reflects it after edge N+1.
  - edgecapture bit set at edge N+2.
  - irq asserted at edge N+3, if the bit is masked in.
- Pulses shorter than 1 clk may be missed; this is acceptable.
- Writes with chipselect=0 have no effect.

Optional Feature:
- Macro: PIO_IN_DEBOUNCE_EN.
- When defined, each bit gets a counter of clog2(DEBOUNCE_CYCLES+1) bits.
  - The counter resets to 0 whenever sync2 equals the stable value, or when sync2 changes.
  - When sync2 differs from the stable value for DEBOUNCE_CYCLES consecutive clk, the stable value takes sync2 and the counter clears.
  - "in" = stable value. Total latency grows by DEBOUNCE_CYCLES clk.
  - The stable value resets to 0.
- When undefined, the counter logic is absent and "in" = sync2.

Test Plan:
- Reset with in_port=10'h3FF held high, EDGE_TYPE=0 → reads: addr0=0x3FF after 2 clk; addr3=0 forever; irq=0.
- irqmask=0x001; drive in_port[0] 0→1 at edge N → addr3=0x001 at N+2; irq=1 at N+3. Then write 0x001 to addr3 → irq=0 one clk later and addr3=0.
- irqmask=0; toggle bit 5 rising → addr3=0x020 and irq stays 0. Then write irqmask=0x020 → irq=1 one clk later.
- A new rising edge on bit 2 coincides with a W1C write of 0x004 to addr3 → addr3 bit 2 remains 1 and irq stays asserted.
- EDGE_TYPE=2: bit 3 pulses 1 for 4 clk → edgecapture bit 3 set by the rise. Clear it; the fall sets it again.
- With PIO_IN_DEBOUNCE_EN and DEBOUNCE_CYCLES=16:
  - bit 0 glitches high for 10 clk → no data change, no capture.
  - held high 20 clk → data bit 0 = 1 after 2+16 clk, capture bit set next clk.
